// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: initiator side of the multi-cycle MIPS register-file port.
// Reads rs/rt into operand latches, then issues one write-back to rt, rd or $ra.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   instr_valid, instr, ready      instruction offer (accepted in IDLE only)
//   A1, A2, RD1, RD2               RF read addresses (registered) and read data
//   opA, opB, opnd_valid           latched operands and their one-cycle strobe
//   wb_valid, wb_en, wb_sel,       write-back offer (sampled in WAIT_WB only)
//   wb_data
//   A3, WD, RFWr                   RF write port (registered, single-cycle RFWr)
//   wb_done, bad_sel               write-back completion / reserved-select strobes
module rf_access_ctrl #(
    parameter int DW     = 32,
    parameter int RA_IDX = 31
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          instr_valid,
    input  logic [31:0]   instr,
    output logic          ready,
    output logic [4:0]    A1,
    output logic [4:0]    A2,
    input  logic [DW-1:0] RD1,
    input  logic [DW-1:0] RD2,
    output logic [DW-1:0] opA,
    output logic [DW-1:0] opB,
    output logic          opnd_valid,
    input  logic          wb_valid,
    input  logic          wb_en,
    input  logic [1:0]    wb_sel,
    input  logic [DW-1:0] wb_data,
    output logic [4:0]    A3,
    output logic [DW-1:0] WD,
    output logic          RFWr,
    output logic          wb_done,
    output logic          bad_sel
);

    localparam logic [4:0] RA = RA_IDX[4:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_OPND,
        S_WAIT_WB,
        S_WRITE
    } state_e;

    state_e        state_q, state_d;
    logic [4:0]    a1_q, a1_d;
    logic [4:0]    a2_q, a2_d;
    logic [4:0]    rd_q, rd_d;
    logic [4:0]    a3_q, a3_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic          rfwr_q, rfwr_d;
    logic          done_q, done_d;
    logic          bad_q, bad_d;
    logic [4:0]    widx;

    logic unused_instr;
    assign unused_instr = ^{instr[31:26], instr[10:0]};

    // A2 already holds rt from acceptance, so it doubles as the rt target.
    always_comb begin
        widx = '0;
        case (wb_sel)
            2'b00:   widx = a2_q;
            2'b01:   widx = rd_q;
            2'b10:   widx = RA;
            default: widx = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        rd_d    = rd_q;
        a3_d    = a3_q;
        wd_d    = wd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rfwr_d  = 1'b0;
        done_d  = 1'b0;
        bad_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    a1_d    = instr[25:21];
                    a2_d    = instr[20:16];
                    rd_d    = instr[15:11];
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                opa_d   = RD1;
                opb_d   = RD2;
                state_d = S_OPND;
            end
            S_OPND: begin
                state_d = S_WAIT_WB;
            end
            S_WAIT_WB: begin
                if (wb_valid) begin
                    state_d = S_WRITE;
                    done_d  = 1'b1;
                    if (wb_en) begin
                        if (wb_sel == 2'b11) begin
                            bad_d = 1'b1;
                        end else begin
                            a3_d   = widx;
                            wd_d   = wb_data;
                            // $0 is hardwired: address it but never strobe.
                            rfwr_d = (widx != 5'd0);
                        end
                    end
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            a1_q    <= '0;
            a2_q    <= '0;
            rd_q    <= '0;
            a3_q    <= '0;
            wd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rfwr_q  <= 1'b0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            rd_q    <= rd_d;
            a3_q    <= a3_d;
            wd_q    <= wd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rfwr_q  <= rfwr_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign opnd_valid = (state_q == S_OPND);
    assign A1         = a1_q;
    assign A2         = a2_q;
    assign A3         = a3_q;
    assign WD         = wd_q;
    assign opA        = opa_q;
    assign opB        = opb_q;
    assign RFWr       = rfwr_q;
    assign wb_done    = done_q;
    assign bad_sel    = bad_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: scoreboard bench for rf_access_ctrl with a behavioural RF.
// Operand and write-back expectations are queued at drive time, popped on strobes.
module tb_rf_access_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr = '0;
    logic          ready;
    logic [4:0]    A1, A2, A3;
    logic [DW-1:0] RD1, RD2, opA, opB, WD;
    logic          opnd_valid;
    logic          wb_valid = 1'b0;
    logic          wb_en = 1'b0;
    logic [1:0]    wb_sel = 2'b00;
    logic [DW-1:0] wb_data = '0;
    logic          RFWr, wb_done, bad_sel;

    rf_access_ctrl #(.DW(DW), .RA_IDX(31)) dut (
        .clk(clk), .rstn(rstn),
        .instr_valid(instr_valid), .instr(instr), .ready(ready),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .opA(opA), .opB(opB), .opnd_valid(opnd_valid),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_sel(wb_sel),
        .wb_data(wb_data),
        .A3(A3), .WD(WD), .RFWr(RFWr),
        .wb_done(wb_done), .bad_sel(bad_sel)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rf [32];
    bit            rf_ok = 1'b0;

    assign RD1 = rf[A1];
    assign RD2 = rf[A2];

    always @(negedge clk) begin
        if (!rf_ok) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
            rf[28] <= 32'h0000_1800;
            rf[29] <= 32'h0000_2ffe;
            rf_ok  <= 1'b1;
        end else if (RFWr && A3 != 5'd0) begin
            rf[A3] <= WD;
        end
    end

    typedef struct packed {
        logic          rfwr;
        logic [4:0]    a3;
        logic [DW-1:0] wd;
        logic          bad;
        logic          chk;
    } wexp_t;

    wexp_t           wq [$];
    logic [2*DW-1:0] opq [$];
    logic [DW-1:0]   exp_rf [32];
    int              checks = 0;
    int              errors = 0;
    logic            prev_rfwr = 1'b0;
    logic [4:0]      cur_rt = '0;
    logic [4:0]      cur_rd = '0;

    // Advance one edge, then score whatever the DUT presented.
    task automatic step();
        logic [2*DW-1:0] eo;
        wexp_t           ew;
        @(posedge clk);
        #1;
        if (opnd_valid) begin
            checks++;
            if (opq.size() == 0) begin
                errors++;
                $display("FAIL opnd_unexpected: opA=%h opB=%h", opA, opB);
            end else begin
                eo = opq.pop_front();
                if ({opA, opB} !== eo) begin
                    errors++;
                    $display("FAIL opnd: got %h/%h want %h/%h",
                             opA, opB, eo[2*DW-1:DW], eo[DW-1:0]);
                end
            end
        end
        if (wb_done) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: RFWr=%b A3=%0d", RFWr, A3);
            end else begin
                ew = wq.pop_front();
                if (RFWr !== ew.rfwr || bad_sel !== ew.bad ||
                    (ew.chk && (A3 !== ew.a3 || WD !== ew.wd))) begin
                    errors++;
                    $display("FAIL wb: got RFWr=%b bad=%b A3=%0d WD=%h want %b %b %0d %h",
                             RFWr, bad_sel, A3, WD, ew.rfwr, ew.bad, ew.a3, ew.wd);
                end
                if (ew.rfwr) exp_rf[ew.a3] = ew.wd;
            end
        end
        if (RFWr) begin
            checks++;
            if (!wb_done || prev_rfwr) begin
                errors++;
                $display("FAIL rfwr_pulse: RFWr=%b wb_done=%b prev=%b want single pulse with wb_done",
                         RFWr, wb_done, prev_rfwr);
            end
        end
        prev_rfwr = RFWr;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, output int lat);
        int n;
        instr       = {6'h23, rs, rt, rd, 11'h0};
        instr_valid = 1'b1;
        opq.push_back({exp_rf[rs], exp_rf[rt]});
        cur_rt = rt;
        cur_rd = rd;
        step();
        instr_valid = 1'b0;
        n = 1;
        while (!opnd_valid && n < 10) begin
            step();
            n++;
        end
        lat = n;
        if (!opnd_valid) begin
            checks++;
            errors++;
            $display("FAIL opnd_timeout: no opnd_valid within %0d cycles", n);
        end
    endtask

    task automatic wb(input logic en, input logic [1:0] sel,
                      input logic [DW-1:0] d);
        wexp_t      e;
        logic [4:0] idx;
        int         n;
        idx    = (sel == 2'b00) ? cur_rt : (sel == 2'b01) ? cur_rd : 5'd31;
        e.rfwr = en && sel != 2'b11 && idx != 5'd0;
        e.a3   = idx;
        e.wd   = d;
        e.bad  = en && sel == 2'b11;
        e.chk  = en && sel != 2'b11;
        wq.push_back(e);
        wb_en    = en;
        wb_sel   = sel;
        wb_data  = d;
        wb_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!wb_done && n < 6);
        wb_valid = 1'b0;
        if (!wb_done) begin
            checks++;
            errors++;
            $display("FAIL wb_timeout: no wb_done within %0d cycles", n);
        end
        step();
    endtask

    task automatic chk_idle_zero(input string tag);
        checks++;
        if (ready !== 1'b1 || RFWr !== 1'b0 || wb_done !== 1'b0 ||
            bad_sel !== 1'b0 || opnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_ctl: ready=%b RFWr=%b done=%b bad=%b ov=%b want 1 0 0 0 0",
                     tag, ready, RFWr, wb_done, bad_sel, opnd_valid);
        end
        checks++;
        if ({A1, A2, A3} !== 15'd0 || WD !== '0 || opA !== '0 || opB !== '0) begin
            errors++;
            $display("FAIL %s_regs: A1=%0d A2=%0d A3=%0d WD=%h opA=%h opB=%h want all 0",
                     tag, A1, A2, A3, WD, opA, opB);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        chk_idle_zero("reset");
        rstn = 1'b1;
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready=%b want 1", ready);
        end
    endtask

    task automatic test_read();
        int lat;
        issue(5'd28, 5'd29, 5'd0, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL read_latency: got %0d want 2", lat);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL read_ready: got %b want 0", ready);
        end
        wb(1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_write_rd();
        int lat;
        issue(5'd28, 5'd29, 5'd8, lat);
        wb(1'b1, 2'b01, 32'hDEAD_BEEF);
        issue(5'd8, 5'd28, 5'd0, lat);
        checks++;
        if (opA !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reread_rd: opA=%h want deadbeef", opA);
        end
        wb(1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_link_zero();
        int lat;
        issue(5'd1, 5'd2, 5'd3, lat);
        wb(1'b1, 2'b10, 32'h0040_0010);
        issue(5'd31, 5'd0, 5'd0, lat);
        wb(1'b1, 2'b00, 32'h1234_5678);
        issue(5'd0, 5'd31, 5'd0, lat);
        checks++;
        if (opA !== 32'h0 || opB !== 32'h0040_0010) begin
            errors++;
            $display("FAIL link_zero: opA=%h opB=%h want 0 00400010", opA, opB);
        end
        wb(1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_nowrite_bad();
        int lat;
        issue(5'd28, 5'd8, 5'd9, lat);
        wb(1'b0, 2'b01, 32'hAAAA_5555);
        issue(5'd9, 5'd28, 5'd10, lat);
        wb(1'b1, 2'b11, 32'h5555_AAAA);
        issue(5'd9, 5'd10, 5'd0, lat);
        checks++;
        if (opA !== 32'h0 || opB !== 32'h0) begin
            errors++;
            $display("FAIL nowrite_regs: opA=%h opB=%h want 0 0", opA, opB);
        end
        wb(1'b0, 2'b00, 32'h0);
    endtask

    task automatic test_wait_ignore();
        int            lat;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
        ea = exp_rf[28];
        eb = exp_rf[8];
        issue(5'd28, 5'd8, 5'd11, lat);
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                instr       = {6'h0, 5'd29, 5'd31, 5'd12, 11'h0};
                instr_valid = 1'b1;
            end else begin
                instr_valid = 1'b0;
            end
            step();
            checks++;
            if (ready !== 1'b0 || opA !== ea || opB !== eb) begin
                errors++;
                $display("FAIL wait_hold: ready=%b opA=%h opB=%h want 0 %h %h",
                         ready, opA, opB, ea, eb);
            end
        end
        instr_valid = 1'b0;
        wb(1'b1, 2'b01, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (ready !== 1'b1 || opq.size() != 0) begin
            errors++;
            $display("FAIL wait_ignore: ready=%b pending=%0d want 1 0",
                     ready, opq.size());
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        instr       = {6'h0, 5'd28, 5'd11, 5'd0, 11'h0};
        instr_valid = 1'b1;
        opq.push_back({exp_rf[28], exp_rf[11]});
        opq.push_back({exp_rf[28], exp_rf[11]});
        cur_rt = 5'd11;
        cur_rd = 5'd0;
        step();
        step();
        wb(1'b0, 2'b00, 32'h0);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: ready=%b want 1", ready);
        end
        step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: ready=%b want 0", ready);
        end
        instr_valid = 1'b0;
        step();
        wb(1'b0, 2'b00, 32'h0);
        lat = 0;
    endtask

    task automatic test_reset_mid();
        int            lat;
        logic [DW-1:0] old;
        issue(5'd28, 5'd29, 5'd5, lat);
        step();
        rstn = 1'b0;
        #1;
        chk_idle_zero("rst_wait");
        step();
        rstn = 1'b1;
        step();
        old = exp_rf[9];
        issue(5'd28, 5'd29, 5'd9, lat);
        wb_en    = 1'b1;
        wb_sel   = 2'b01;
        wb_data  = 32'h0BAD_0BAD;
        wb_valid = 1'b1;
        wq.push_back('{rfwr: 1'b1, a3: 5'd9, wd: 32'h0BAD_0BAD,
                       bad: 1'b0, chk: 1'b1});
        step();
        step();
        wb_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk_idle_zero("rst_write");
        exp_rf[9] = old;
        wq.delete();
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: ready=%b want 1", ready);
        end
        issue(5'd9, 5'd0, 5'd0, lat);
        wb(1'b0, 2'b00, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        exp_rf[28] = 32'h0000_1800;
        exp_rf[29] = 32'h0000_2ffe;
        test_reset();
        test_read();
        test_write_rd();
        test_link_zero();
        test_nowrite_bad();
        test_wait_ignore();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (opq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL drain: opq=%0d wq=%0d want 0 0", opq.size(), wq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
